// File: rtl/iot_responder_pkg.sv
// Shared types and constants for the IOT responder: bus/printer state
// encodings, IOT function-bit positions and default device codes.
package iot_responder_pkg;

  typedef enum logic [1:0] {IDLE, DECODE, RESPOND} bus_state_t;
  typedef enum logic [1:0] {P_IDLE, P_SEND, P_WAIT} prt_state_t;

  localparam int IOT_SKIP_BIT = 0;
  localparam int IOT_CLR_BIT  = 1;
  localparam int IOT_XFER_BIT = 2;

  localparam logic [5:0] KBD_DEV_DEFAULT = 6'o03;
  localparam logic [5:0] TTY_DEV_DEFAULT = 6'o04;

endpackage

// File: rtl/iot_responder_printer.sv
// Printer handshake engine: offers a buffered character until accepted,
// then waits PRT_DELAY cycles and pulses done to set the teleprinter flag.
module iot_printer
  import iot_responder_pkg::*;
#(
  parameter int PRT_DELAY = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] start_char,
  output logic       prt_valid,
  output logic [7:0] prt_char,
  input  logic       prt_ready,
  output logic       done
);

  prt_state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] char_q, char_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= P_IDLE;
      cnt    <= 8'd0;
      char_q <= 8'd0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      char_q <= char_next;
    end
  end

  // A start outside P_IDLE is simply not looked at, so the character is dropped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    char_next  = char_q;
    prt_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      P_IDLE: begin
        if (start) begin
          char_next  = start_char;
          state_next = P_SEND;
        end
      end
      P_SEND: begin
        prt_valid = 1'b1;
        if (prt_ready) begin
          cnt_next   = 8'(PRT_DELAY - 1);
          state_next = P_WAIT;
        end
      end
      P_WAIT: begin
        if (cnt == 8'd0) begin
          done       = 1'b1;
          state_next = P_IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: state_next = P_IDLE;
    endcase
  end

  assign prt_char = char_q;

endmodule

// File: rtl/iot_responder.sv
// PDP-8 style IOT responder for keyboard and teleprinter devices.
// Optional feature macro: KBD_OVERRUN_EN (keyboard overrun capture and status bit).
module iot_responder
  import iot_responder_pkg::*;
#(
  parameter logic [5:0] KBD_DEV   = KBD_DEV_DEFAULT,
  parameter logic [5:0] TTY_DEV   = TTY_DEV_DEFAULT,
  parameter int         PRT_DELAY = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iot_req,
  input  logic [11:0] iot_ir,
  input  logic [7:0]  iot_dataout,
  output logic        iot_ack,
  output logic [7:0]  iot_datain,
  output logic        iot_skip,
  output logic        iot_clr_ac,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_char,
  output logic        kbd_ready,
  output logic        prt_valid,
  output logic [7:0]  prt_char,
  input  logic        prt_ready
);

  bus_state_t state, state_next;
  logic [8:0] ir_q;
  logic [7:0] dataout_q;
  logic [7:0] datain_q;
  logic       skip_q, clr_q;
  logic       kbd_flag, tty_flag;
  logic [7:0] kbd_buf, kbd_read;
  logic       kbd_sel, tty_sel, responding;
  logic       kbd_clear, tty_clear, prt_start, prt_done;
  logic       unused_ir_opcode;

  // The opcode field is implied by iot_req; only the device/function bits matter here.
  assign unused_ir_opcode = ^iot_ir[11:9];

  assign kbd_sel    = (ir_q[8:3] == KBD_DEV);
  assign tty_sel    = (ir_q[8:3] == TTY_DEV);
  assign responding = (state == RESPOND);
  assign kbd_clear  = responding & kbd_sel & ir_q[IOT_CLR_BIT];
  assign tty_clear  = responding & tty_sel & ir_q[IOT_CLR_BIT];
  assign prt_start  = responding & tty_sel & ir_q[IOT_XFER_BIT];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iot_req) state_next = DECODE;
      DECODE:  state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags and buffer are sampled in DECODE so RESPOND presents a stable snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q      <= 9'd0;
      dataout_q <= 8'd0;
      datain_q  <= 8'd0;
      skip_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      if (state == IDLE && iot_req) begin
        ir_q      <= iot_ir[8:0];
        dataout_q <= iot_dataout;
      end
      if (state == DECODE) begin
        skip_q   <= ir_q[IOT_SKIP_BIT] & ((kbd_sel & kbd_flag) | (tty_sel & tty_flag));
        clr_q    <= kbd_sel & ir_q[IOT_CLR_BIT];
        datain_q <= (kbd_sel & ir_q[IOT_XFER_BIT]) ? kbd_read : 8'd0;
      end
    end
  end

  assign iot_ack    = responding;
  assign iot_datain = responding ? datain_q : 8'd0;
  assign iot_skip   = responding & skip_q;
  assign iot_clr_ac = responding & clr_q;

`ifdef KBD_OVERRUN_EN
  logic kbd_overrun;

  assign kbd_ready = 1'b1;
  assign kbd_read  = {kbd_buf[7] | kbd_overrun, kbd_buf[6:0]};

  // A new character always lands; losing an unread one raises the sticky overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      kbd_flag    <= 1'b0;
      kbd_buf     <= 8'd0;
      kbd_overrun <= 1'b0;
    end else begin
      if (kbd_clear) begin
        kbd_flag    <= 1'b0;
        kbd_overrun <= 1'b0;
      end
      if (kbd_valid) begin
        kbd_buf  <= kbd_char;
        kbd_flag <= 1'b1;
        if (kbd_flag && !kbd_clear) kbd_overrun <= 1'b1;
      end
    end
  end
`else
  // Holding off capture during a flag clear keeps the clear from eating a fresh char.
  assign kbd_ready = ~kbd_flag & ~kbd_clear;
  assign kbd_read  = kbd_buf;

  always_ff @(posedge clock) begin
    if (reset) begin
      kbd_flag <= 1'b0;
      kbd_buf  <= 8'd0;
    end else begin
      if (kbd_clear) kbd_flag <= 1'b0;
      if (kbd_valid && kbd_ready) begin
        kbd_buf  <= kbd_char;
        kbd_flag <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset)          tty_flag <= 1'b0;
    else if (prt_done)  tty_flag <= 1'b1;
    else if (tty_clear) tty_flag <= 1'b0;
  end

  iot_printer #(
    .PRT_DELAY(PRT_DELAY)
  ) u_printer (
    .clock     (clock),
    .reset     (reset),
    .start     (prt_start),
    .start_char(dataout_q),
    .prt_valid (prt_valid),
    .prt_char  (prt_char),
    .prt_ready (prt_ready),
    .done      (prt_done)
  );

endmodule

// File: tb/tb_iot_responder.sv
// Directed self-checking bench for iot_responder (default parameters).
// Overrun vectors run only when KBD_OVERRUN_EN is defined.
module tb_iot_responder;

`ifdef KBD_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        iot_req;
  logic [11:0] iot_ir;
  logic [7:0]  iot_dataout;
  logic        iot_ack;
  logic [7:0]  iot_datain;
  logic        iot_skip;
  logic        iot_clr_ac;
  logic        kbd_valid;
  logic [7:0]  kbd_char;
  logic        kbd_ready;
  logic        prt_valid;
  logic [7:0]  prt_char;
  logic        prt_ready;

  int checkCount = 0;
  int errorCount = 0;

  iot_responder dut (
    .clock      (clock),
    .reset      (reset),
    .iot_req    (iot_req),
    .iot_ir     (iot_ir),
    .iot_dataout(iot_dataout),
    .iot_ack    (iot_ack),
    .iot_datain (iot_datain),
    .iot_skip   (iot_skip),
    .iot_clr_ac (iot_clr_ac),
    .kbd_valid  (kbd_valid),
    .kbd_char   (kbd_char),
    .kbd_ready  (kbd_ready),
    .prt_valid  (prt_valid),
    .prt_char   (prt_char),
    .prt_ready  (prt_ready)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issues one IOT and checks the response cycle; called and returns 1ns after an edge.
  task automatic applyStimulus(input logic [11:0] ir, input logic [7:0] dout,
                               input logic expSkip, input logic [7:0] expData,
                               input logic expClr, input logic expReady);
    iot_ir      = ir;
    iot_dataout = dout;
    iot_req     = 1'b1;
    tick(1);
    iot_req = 1'b0;
    checkOutput($sformatf("ack_decode_%o", ir), 8'(iot_ack), 8'd0);
    tick(1);
    checkOutput($sformatf("ack_%o", ir), 8'(iot_ack), 8'd1);
    checkOutput($sformatf("skip_%o", ir), 8'(iot_skip), 8'(expSkip));
    checkOutput($sformatf("datain_%o", ir), iot_datain, expData);
    checkOutput($sformatf("clr_ac_%o", ir), 8'(iot_clr_ac), 8'(expClr));
    checkOutput($sformatf("kbd_ready_respond_%o", ir), 8'(kbd_ready), 8'(expReady));
    tick(1);
    checkOutput($sformatf("ack_after_%o", ir), 8'(iot_ack), 8'd0);
  endtask

  task automatic sendKey(input logic [7:0] ch);
    kbd_char  = ch;
    kbd_valid = 1'b1;
    tick(1);
    kbd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    iot_req     = 1'b1;
    iot_ir      = 12'o6031;
    iot_dataout = 8'h00;
    kbd_valid   = 1'b1;
    kbd_char    = 8'h77;
    prt_ready   = 1'b1;
    tick(3);
    checkOutput("rst_ack", 8'(iot_ack), 8'd0);
    checkOutput("rst_datain", iot_datain, 8'h00);
    checkOutput("rst_skip", 8'(iot_skip), 8'd0);
    checkOutput("rst_clr_ac", 8'(iot_clr_ac), 8'd0);
    checkOutput("rst_prt_valid", 8'(prt_valid), 8'd0);
    checkOutput("rst_prt_char", prt_char, 8'h00);
    checkOutput("rst_kbd_ready", 8'(kbd_ready), 8'd1);
    reset     = 1'b0;
    iot_req   = 1'b0;
    kbd_valid = 1'b0;
    prt_ready = 1'b0;
    tick(1);

    // Keyboard: empty, capture, skip, read-and-clear, empty again.
    applyStimulus(12'o6031, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    sendKey(8'h41);
    checkOutput("kbd_ready_full", 8'(kbd_ready), 8'(OVR));
    applyStimulus(12'o6031, 8'h00, 1'b1, 8'h00, 1'b0, OVR);
    applyStimulus(12'o6036, 8'h00, 1'b0, 8'h41, 1'b1, OVR);
    checkOutput("kbd_ready_after_read", 8'(kbd_ready), 8'd1);
    applyStimulus(12'o6031, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(12'o6032, 8'h00, 1'b0, 8'h00, 1'b1, OVR);

    // Request held high across the whole transaction yields a single ack.
    iot_ir  = 12'o6031;
    iot_req = 1'b1;
    tick(3);
    iot_req = 1'b0;
    checkOutput("held_req_idle", 8'(iot_ack), 8'd0);
    tick(1);
    checkOutput("held_req_no_reack", 8'(iot_ack), 8'd0);

    applyStimulus(12'o6101, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);

`ifdef KBD_OVERRUN_EN
    sendKey(8'h31);
    sendKey(8'h32);
    applyStimulus(12'o6034, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b1);
    applyStimulus(12'o6032, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(12'o6034, 8'h00, 1'b0, 8'h32, 1'b0, 1'b1);
`endif

    // Printer run 1: start, a dropped second start, acceptance, flag timing.
    applyStimulus(12'o6046, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("prt_valid_started", 8'(prt_valid), 8'd1);
    checkOutput("prt_char_started", prt_char, 8'h5A);
    applyStimulus(12'o6044, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("prt_valid_busy", 8'(prt_valid), 8'd1);
    checkOutput("prt_char_stable", prt_char, 8'h5A);
    prt_ready = 1'b1;
    tick(1);
    prt_ready = 1'b0;
    checkOutput("prt_valid_accepted", 8'(prt_valid), 8'd0);
    tick(6);
    applyStimulus(12'o6041, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(12'o6041, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    checkOutput("prt_no_second_print", 8'(prt_valid), 8'd0);

    // Printer run 2: clear flag and start together, flag exactly PRT_DELAY after accept.
    applyStimulus(12'o6046, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("prt_char_run2", prt_char, 8'hA5);
    applyStimulus(12'o6041, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    prt_ready = 1'b1;
    tick(1);
    prt_ready = 1'b0;
    tick(7);
    applyStimulus(12'o6041, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);

    // Reset in P_WAIT with competing inputs asserted.
    sendKey(8'h44);
    applyStimulus(12'o6044, 8'h11, 1'b0, 8'h00, 1'b0, OVR);
    prt_ready = 1'b1;
    tick(1);
    prt_ready = 1'b0;
    tick(3);
    reset     = 1'b1;
    iot_ir    = 12'o6031;
    iot_req   = 1'b1;
    kbd_char  = 8'h55;
    kbd_valid = 1'b1;
    prt_ready = 1'b1;
    tick(1);
    checkOutput("rst_wait_prt_valid", 8'(prt_valid), 8'd0);
    checkOutput("rst_wait_kbd_ready", 8'(kbd_ready), 8'd1);
    checkOutput("rst_wait_prt_char", prt_char, 8'h00);
    checkOutput("rst_wait_ack", 8'(iot_ack), 8'd0);
    reset     = 1'b0;
    iot_req   = 1'b0;
    kbd_valid = 1'b0;
    prt_ready = 1'b0;
    tick(2);
    checkOutput("rst_req_dropped", 8'(iot_ack), 8'd0);
    tick(12);
    applyStimulus(12'o6041, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(12'o6031, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(12'o6034, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
